control_towerplacer: RTL and testbench

//  Moore FSM that sequences the tower-placer datapath: cursor init, cursor square draw, erase/move right, erase/move down, erase/draw tower.

---
 rtl/control_towerplacer.sv | 245 ++++++++++++++++++++++++
 tb/tb_control_towerplacer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/control_towerplacer.sv
// control_towerplacer
//   Moore sequencer for the tower-placer datapath. It steps through cursor init,
//   cursor square draw, erase/move right, erase/move down and erase/draw tower.
//   It keeps a mirror of the cursor position and an occupancy bitmap, so a tower
//   is never drawn on a cell that already holds one.
// Ports
//   clk, resetn                       clock; resetn is asynchronous and active-high
//   key_right/key_down/key_place      debounced key levels, acted on by rising edge in S_IDLE
//   square_done, erase_square_done,
//   tower_done, valid                 datapath feedback levels
//   top_left .. draw_tower            one-hot control strobes (none in S_IDLE)
//   busy                              high outside S_IDLE
//   place_rejected, fault             single-cycle status pulses
//   cursor_col, cursor_row            mirrored cursor position
//   tower_count                       number of occupied cells
module control_towerplacer #(
  parameter int unsigned GRID_COLS    = 8,
  parameter int unsigned GRID_ROWS    = 6,
  parameter int unsigned DONE_TIMEOUT = 1023,
  localparam int unsigned COL_W = (GRID_COLS > 1) ? $clog2(GRID_COLS) : 1,
  localparam int unsigned ROW_W = (GRID_ROWS > 1) ? $clog2(GRID_ROWS) : 1,
  localparam int unsigned CNT_W = $clog2(GRID_COLS * GRID_ROWS + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             key_right,
  input  logic             key_down,
  input  logic             key_place,
  input  logic             square_done,
  input  logic             erase_square_done,
  input  logic             tower_done,
  input  logic             valid,
  output logic             top_left,
  output logic             draw_square,
  output logic             move_right,
  output logic             move_down,
  output logic             move_right_wait,
  output logic             move_down_wait,
  output logic             erase_square_right,
  output logic             erase_square_down,
  output logic             erase_square_tower,
  output logic             draw_tower,
  output logic             busy,
  output logic             place_rejected,
  output logic             fault,
  output logic [COL_W-1:0] cursor_col,
  output logic [ROW_W-1:0] cursor_row,
  output logic [CNT_W-1:0] tower_count
);

  localparam int unsigned CELLS = GRID_COLS * GRID_ROWS;
  localparam int unsigned IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam int unsigned TMR_W = $clog2(DONE_TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_TOP_LEFT,
    S_DRAW_SQUARE,
    S_IDLE,
    S_ERASE_RIGHT,
    S_MOVE_RIGHT,
    S_MOVE_RIGHT_WAIT,
    S_ERASE_DOWN,
    S_MOVE_DOWN,
    S_MOVE_DOWN_WAIT,
    S_ERASE_TOWER,
    S_DRAW_TOWER
  } state_t;

  state_t           state, state_next;
  logic [2:0]       key_prev;
  logic [2:0]       key_edge;
  logic [TMR_W-1:0] timer;
  logic [CELLS-1:0] occupancy;
  logic [IDX_W-1:0] cell_idx;
  logic             occupied;
  logic             expired;
  logic             timing_c;
  logic             advance_c;
  logic             fault_c;
  logic             reject_c;
  logic             col_step_c;
  logic             row_step_c;
  logic             place_c;

  // Rising edges of the key levels, ordered {place, right, down}.
  assign key_edge = {key_place, key_right, key_down} & ~key_prev;

  assign cell_idx = IDX_W'(cursor_row) * IDX_W'(GRID_COLS) + IDX_W'(cursor_col);
  assign occupied = occupancy[cell_idx];
  assign expired  = (timer == TMR_W'(DONE_TIMEOUT - 1));

  // State register
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) state <= S_TOP_LEFT;
    else        state <= state_next;
  end

  // Next-state and event decode
  always_comb begin
    state_next = state;
    timing_c   = 1'b0;
    advance_c  = 1'b0;
    fault_c    = 1'b0;
    reject_c   = 1'b0;
    col_step_c = 1'b0;
    row_step_c = 1'b0;
    place_c    = 1'b0;
    case (state)
      S_TOP_LEFT: state_next = S_DRAW_SQUARE;
      S_DRAW_SQUARE: begin
        timing_c  = 1'b1;
        advance_c = square_done;
        if (square_done) state_next = S_IDLE;
      end
      S_IDLE: begin
        // place > right > down; the losing edges are simply dropped
        if (key_edge[2]) begin
          if (occupied) reject_c   = 1'b1;
          else          state_next = S_ERASE_TOWER;
        end else if (key_edge[1]) begin
          state_next = S_ERASE_RIGHT;
        end else if (key_edge[0]) begin
          state_next = S_ERASE_DOWN;
        end
      end
      S_ERASE_RIGHT: begin
        timing_c  = 1'b1;
        advance_c = erase_square_done;
        if (erase_square_done) state_next = S_MOVE_RIGHT;
      end
      S_MOVE_RIGHT: begin
        timing_c  = 1'b1;
        advance_c = valid;
        if (valid) begin
          state_next = S_MOVE_RIGHT_WAIT;
          col_step_c = 1'b1;
        end
      end
      S_MOVE_RIGHT_WAIT: state_next = S_DRAW_SQUARE;
      S_ERASE_DOWN: begin
        timing_c  = 1'b1;
        advance_c = erase_square_done;
        if (erase_square_done) state_next = S_MOVE_DOWN;
      end
      S_MOVE_DOWN: begin
        timing_c  = 1'b1;
        advance_c = valid;
        if (valid) begin
          state_next = S_MOVE_DOWN_WAIT;
          row_step_c = 1'b1;
        end
      end
      S_MOVE_DOWN_WAIT: state_next = S_DRAW_SQUARE;
      S_ERASE_TOWER: begin
        timing_c  = 1'b1;
        advance_c = erase_square_done;
        if (erase_square_done) state_next = S_DRAW_TOWER;
      end
      S_DRAW_TOWER: begin
        timing_c  = 1'b1;
        advance_c = tower_done;
        if (tower_done) begin
          state_next = S_DRAW_SQUARE;
          place_c    = 1'b1;
        end
      end
      default: state_next = S_TOP_LEFT;
    endcase
    // A late done still wins over the timeout in the same cycle.
    if (timing_c && !advance_c && expired) begin
      state_next = S_TOP_LEFT;
      fault_c    = 1'b1;
    end
  end

  // Strobes and busy are registered from state_next, so they track the state register exactly.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      top_left           <= 1'b1;
      draw_square        <= 1'b0;
      move_right         <= 1'b0;
      move_down          <= 1'b0;
      move_right_wait    <= 1'b0;
      move_down_wait     <= 1'b0;
      erase_square_right <= 1'b0;
      erase_square_down  <= 1'b0;
      erase_square_tower <= 1'b0;
      draw_tower         <= 1'b0;
      busy               <= 1'b1;
    end else begin
      top_left           <= (state_next == S_TOP_LEFT);
      draw_square        <= (state_next == S_DRAW_SQUARE);
      move_right         <= (state_next == S_MOVE_RIGHT);
      move_down          <= (state_next == S_MOVE_DOWN);
      move_right_wait    <= (state_next == S_MOVE_RIGHT_WAIT);
      move_down_wait     <= (state_next == S_MOVE_DOWN_WAIT);
      erase_square_right <= (state_next == S_ERASE_RIGHT);
      erase_square_down  <= (state_next == S_ERASE_DOWN);
      erase_square_tower <= (state_next == S_ERASE_TOWER);
      draw_tower         <= (state_next == S_DRAW_TOWER);
      busy               <= (state_next != S_IDLE);
    end
  end

  // Key history, status pulses and the wait timer
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      key_prev       <= 3'b111;
      place_rejected <= 1'b0;
      fault          <= 1'b0;
      timer          <= '0;
    end else begin
      key_prev       <= {key_place, key_right, key_down};
      place_rejected <= reject_c;
      fault          <= fault_c;
      if ((state_next != state) || !timing_c) timer <= '0;
      else                                    timer <= timer + TMR_W'(1);
    end
  end

  // Cursor mirror, occupancy bitmap and tower count
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      cursor_col  <= '0;
      cursor_row  <= '0;
      occupancy   <= '0;
      tower_count <= '0;
    end else begin
      if (state == S_TOP_LEFT) begin
        cursor_col <= '0;
        cursor_row <= '0;
      end else begin
        if (col_step_c)
          cursor_col <= (cursor_col == COL_W'(GRID_COLS - 1)) ? '0 : cursor_col + COL_W'(1);
        if (row_step_c)
          cursor_row <= (cursor_row == ROW_W'(GRID_ROWS - 1)) ? '0 : cursor_row + ROW_W'(1);
      end
      if (place_c) begin
        occupancy[cell_idx] <= 1'b1;
        tower_count         <= tower_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_control_towerplacer.sv
// tb_control_towerplacer
//   Self-checking bench: a datapath responder answers each strobe after a few
//   cycles, and a scoreboard queue holds the expected strobe sequence.
module tb_control_towerplacer;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic       key_right = 1'b0, key_down = 1'b0, key_place = 1'b0;
  logic       square_done = 1'b0, erase_square_done = 1'b0, tower_done = 1'b0, valid = 1'b0;
  logic       top_left, draw_square, move_right, move_down, move_right_wait, move_down_wait;
  logic       erase_square_right, erase_square_down, erase_square_tower, draw_tower;
  logic       busy, place_rejected, fault;
  logic [2:0] cursor_col, cursor_row;
  logic [5:0] tower_count;

  always #5 clk = ~clk;

  control_towerplacer dut (
    .clk(clk), .resetn(resetn),
    .key_right(key_right), .key_down(key_down), .key_place(key_place),
    .square_done(square_done), .erase_square_done(erase_square_done),
    .tower_done(tower_done), .valid(valid),
    .top_left(top_left), .draw_square(draw_square), .move_right(move_right),
    .move_down(move_down), .move_right_wait(move_right_wait), .move_down_wait(move_down_wait),
    .erase_square_right(erase_square_right), .erase_square_down(erase_square_down),
    .erase_square_tower(erase_square_tower), .draw_tower(draw_tower),
    .busy(busy), .place_rejected(place_rejected), .fault(fault),
    .cursor_col(cursor_col), .cursor_row(cursor_row), .tower_count(tower_count)
  );

  // Strobe vector {top_left, draw_square, move_right, move_down, move_right_wait,
  //                move_down_wait, erase_right, erase_down, erase_tower, draw_tower}
  localparam logic [9:0] TL  = 10'h200, DS  = 10'h100, MR  = 10'h080, MD = 10'h040;
  localparam logic [9:0] MRW = 10'h020, MDW = 10'h010, ER  = 10'h008, ED = 10'h004;
  localparam logic [9:0] ET  = 10'h002, DT  = 10'h001, IDL = 10'h000;

  logic [9:0] strb;
  assign strb = {top_left, draw_square, move_right, move_down, move_right_wait,
                 move_down_wait, erase_square_right, erase_square_down,
                 erase_square_tower, draw_tower};

  int         tests = 0;
  int         fails = 0;
  logic [9:0] exp_q[$];
  logic [9:0] prev_strb = 10'h3ff;
  int         age = 0;
  bit         hold_erase = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Scoreboard on strobe changes, then datapath responder driving feedback levels.
  always @(negedge clk) begin
    if (strb !== prev_strb) begin
      check("sb_has_entry", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) check("strobe_seq", strb, exp_q.pop_front());
      age = 0;
    end else begin
      age++;
    end
    prev_strb = strb;
    square_done       = draw_square && age >= 2;
    erase_square_done = (erase_square_right || erase_square_down || erase_square_tower)
                        && age >= 2 && !hold_erase;
    tower_done        = draw_tower && age >= 2;
    valid             = (move_right || move_down) && age >= 2;
  end

  task automatic wait_idle(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy !== 1'b0 && n < 200);
    check(tag, busy, 0);
  endtask

  task automatic release_keys();
    key_right = 1'b0;
    key_down  = 1'b0;
    key_place = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ed_cycles;
    int n;
    exp_q.push_back(TL);
    repeat (3) @(negedge clk);
    // reset state
    check("rst_top_left", top_left, 1);
    check("rst_busy", busy, 1);
    check("rst_count", tower_count, 0);
    check("rst_fault", fault, 0);
    check("rst_reject", place_rejected, 0);

    // 1: release reset
    exp_q.push_back(DS); exp_q.push_back(IDL);
    resetn = 1'b0;
    wait_idle("init_idle");
    check("init_col", cursor_col, 0);
    check("init_row", cursor_row, 0);

    // 2: eight right moves with column wrap
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(ER); exp_q.push_back(MR); exp_q.push_back(MRW);
      exp_q.push_back(DS); exp_q.push_back(IDL);
      key_right = 1'b1;
      wait_idle("right_idle");
      check("right_col", cursor_col, (i + 1) % 8);
      check("right_row", cursor_row, 0);
      release_keys();
    end

    // 3: place at (0,0), then a rejected second place
    exp_q.push_back(ET); exp_q.push_back(DT); exp_q.push_back(DS); exp_q.push_back(IDL);
    key_place = 1'b1;
    wait_idle("place_idle");
    check("place_count", tower_count, 1);
    release_keys();
    key_place = 1'b1;
    @(negedge clk);
    check("reject_pulse", place_rejected, 1);
    check("reject_busy", busy, 0);
    @(negedge clk);
    check("reject_end", place_rejected, 0);
    check("reject_count", tower_count, 1);
    release_keys();

    // 4: move down to (0,1), then place+right together
    exp_q.push_back(ED); exp_q.push_back(MD); exp_q.push_back(MDW);
    exp_q.push_back(DS); exp_q.push_back(IDL);
    key_down = 1'b1;
    wait_idle("down_idle");
    check("down_row", cursor_row, 1);
    release_keys();
    exp_q.push_back(ET); exp_q.push_back(DT); exp_q.push_back(DS); exp_q.push_back(IDL);
    key_place = 1'b1;
    key_right = 1'b1;
    wait_idle("prio_idle");
    check("prio_col", cursor_col, 0);
    check("prio_row", cursor_row, 1);
    check("prio_count", tower_count, 2);
    release_keys();

    // 5: erase stall after a down edge -> fault after exactly 1023 cycles
    hold_erase = 1'b1;
    exp_q.push_back(ED); exp_q.push_back(TL); exp_q.push_back(DS); exp_q.push_back(IDL);
    key_down = 1'b1;
    ed_cycles = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (erase_square_down) ed_cycles++;
    end while (top_left !== 1'b1 && n < 1200);
    check("fault_reached_tl", top_left, 1);
    check("fault_pulse", fault, 1);
    check("fault_cycles", ed_cycles, 1023);
    hold_erase = 1'b0;
    key_down = 1'b0;
    wait_idle("fault_idle");
    check("fault_end", fault, 0);
    check("fault_col", cursor_col, 0);
    check("fault_row", cursor_row, 0);
    check("fault_count", tower_count, 2);
    key_place = 1'b1;
    @(negedge clk);
    check("retain_reject", place_rejected, 1);
    release_keys();

    // 6: reset during DRAW_TOWER at (1,0)
    exp_q.push_back(ER); exp_q.push_back(MR); exp_q.push_back(MRW);
    exp_q.push_back(DS); exp_q.push_back(IDL);
    key_right = 1'b1;
    wait_idle("r6_idle");
    check("r6_col", cursor_col, 1);
    release_keys();
    exp_q.push_back(ET); exp_q.push_back(DT);
    key_place = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (draw_tower !== 1'b1 && n < 50);
    check("saw_draw_tower", draw_tower, 1);
    #2;
    exp_q.push_back(TL);
    resetn = 1'b1;
    key_place = 1'b0;
    @(negedge clk);
    check("midrst_strobes", strb, TL);
    check("midrst_count", tower_count, 0);
    check("midrst_col", cursor_col, 0);
    exp_q.push_back(DS); exp_q.push_back(IDL);
    resetn = 1'b0;
    wait_idle("midrst_idle");
    check("midrst_count2", tower_count, 0);
    exp_q.push_back(ET); exp_q.push_back(DT); exp_q.push_back(DS); exp_q.push_back(IDL);
    key_place = 1'b1;
    wait_idle("cleared_place_idle");
    check("cleared_place_count", tower_count, 1);
    release_keys();

    repeat (2) @(negedge clk);
    check("sb_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
